// File: rtl/rv_pkg.sv
// rv_pkg: shared constants, region codes and fetch FSM states for the RISC-V pipeline
package rv_pkg;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {
    REGION_BIOS = 2'd0,
    REGION_IMEM = 2'd1,
    REGION_NONE = 2'd2
  } region_t;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_region_decode.sv
// pc_region_decode: maps an address's top nibble to a memory region and flags word misalignment
module pc_region_decode
  import rv_pkg::*;
(
  input  logic [3:0] page,
  input  logic [1:0] offset,
  output region_t    region,
  output logic       misaligned
);
  always_comb begin
    region     = (page == 4'h4) ? REGION_BIOS :
                 (page == 4'h1 || page == 4'h3) ? REGION_IMEM : REGION_NONE;
    misaligned = |offset;
  end
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: owns the PC, drives BIOS/IMEM read ports and presents pc/instruction to decode
module ifetch_stage #(
  parameter logic [31:0] RESET_PC    = rv_pkg::RESET_PC,
  parameter int          BIOS_AWIDTH = 12,
  parameter int          IMEM_AWIDTH = 14,
  parameter logic [31:0] NOP_INST    = rv_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [BIOS_AWIDTH-1:0] bios_addra,
  input  logic [31:0]            bios_douta,
  output logic [IMEM_AWIDTH-1:0] imem_addrb,
  input  logic [31:0]            imem_doutb,
  output logic [31:0]            pc_out,
  output logic [31:0]            inst_out,
  output logic                   inst_valid,
  output logic                   fetch_fault
);
  import rv_pkg::*;
  fetch_state_t state_q, state_d;
  region_t      src_q, region;
  logic [31:0]  pc_q, next_pc;
  logic         misaligned, bad_target;
  pc_region_decode u_dec (
    .page      (next_pc[31:28]),
    .offset    (next_pc[1:0]),
    .region    (region),
    .misaligned(misaligned)
  );
  // FAULT holds the faulting PC until a redirect arrives
  always_comb begin
    next_pc    = rst ? RESET_PC :
                 (state_q == BOOT) ? pc_q :
                 redirect ? redirect_pc :
                 (stall || state_q == FAULT) ? pc_q : pc_q + 32'd4;
    bad_target = (region == REGION_NONE) || misaligned;
    state_d    = (state_q == BOOT) ? RUN :
                 (state_q == RUN || redirect) ? (bad_target ? FAULT : RUN) : FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else state_q <= state_d;
    pc_q  <= next_pc;
    src_q <= region;
  end
  always_comb begin
    bios_addra  = next_pc[BIOS_AWIDTH+1:2];
    imem_addrb  = next_pc[IMEM_AWIDTH+1:2];
    pc_out      = pc_q;
    inst_out    = (state_q == FAULT || src_q == REGION_NONE) ? NOP_INST :
                  (src_q == REGION_BIOS) ? bios_douta : imem_doutb;
    inst_valid  = (state_q == RUN) && (src_q != REGION_NONE) && !redirect;
    fetch_fault = (state_q == FAULT);
  end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: randomized scoreboard bench for ifetch_stage against a PC/mode reference model
module tb_ifetch_stage;
  logic        clk = 0, rst = 1, stall = 0, redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic [11:0] bios_addra;
  logic [13:0] imem_addrb;
  logic [31:0] bios_douta, imem_doutb, pc_out, inst_out;
  logic        inst_valid, fetch_fault;
  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic        chk_inst;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t        sb[$];
  int          compared = 0, mismatched = 0;
  bit          mon_on = 0;
  int          m_mode;
  logic [31:0] m_pc;

  ifetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .bios_addra(bios_addra), .bios_douta(bios_douta),
    .imem_addrb(imem_addrb), .imem_doutb(imem_doutb),
    .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bios_douta <= bios_mem[bios_addra];
    imem_doutb <= imem_mem[imem_addrb];
  end

  function automatic bit mapped(input logic [31:0] a);
    return a[31:28] == 4'h4 || a[31:28] == 4'h1 || a[31:28] == 4'h3;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:28] == 4'h4) return bios_mem[a[13:2]];
    return imem_mem[a[15:2]];
  endfunction

  // model modes: 0 boot, 1 run, 2 fault; m_pc is the PC shown to decode this cycle
  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = d; redirect_pc = t;
    e.valid    = (m_mode == 1) && mapped(m_pc) && !d;
    e.fault    = (m_mode == 2);
    e.pc       = m_pc;
    e.chk_inst = e.valid || e.fault;
    e.inst     = e.fault ? 32'h0000_0013 : e.valid ? mem_word(m_pc) : 32'h0;
    sb.push_back(e);
    mon_on = 1;
    if (r) begin
      m_mode = 0;
      m_pc   = 32'h4000_0000;
    end else if (m_mode == 0) m_mode = 1;
    else if (d) begin
      m_pc   = t;
      m_mode = (mapped(t) && t[1:0] == 2'b00) ? 1 : 2;
    end else if (m_mode == 1 && !s) begin
      m_pc = m_pc + 32'd4;
      if (!mapped(m_pc)) m_mode = 2;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_empty: got no expectation, required one at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e.valid});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
        chk("pc_out", pc_out, e.pc);
        if (e.chk_inst) chk("inst_out", inst_out, e.inst);
      end
    end
  end

  initial begin
    bit          r, s, d;
    logic [31:0] t;
    foreach (bios_mem[i]) bios_mem[i] = $urandom;
    foreach (imem_mem[i]) imem_mem[i] = $urandom;
    repeat (2) @(posedge clk);
    m_mode = 0;
    m_pc   = 32'h4000_0000;
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1000_0000);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h4000_0100);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h2000_0000);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h4000_0002);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h4000_0000);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h1FFF_FFF8);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h3000_0000);
    repeat (2) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0);
      t = $urandom;
      t[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0, 1: t[31:28] = 4'h4;
        2: t[31:28] = 4'h1;
        3: t[31:28] = 4'h3;
        4: t[31:28] = 4'h5;
        default: begin
          t[31:28] = 4'h4;
          t[1:0]   = 2'($urandom_range(1, 3));
        end
      endcase
      step(r, s, d, t);
    end
    @(posedge clk);
    #1;
    mon_on = 0;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage of the three-stage RISC-V pipeline.
- Owns the PC and drives the instruction-side read ports of BIOS memory (port A) and IMEM (port B).
- Both memories have 1-cycle synchronous read. The stage selects the returning word and presents pc/instruction/valid to decode.
- Handles boot, stall, branch/jump redirect, and unmapped or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS base).
- BIOS_AWIDTH, 12, BIOS word-address width.
- IMEM_AWIDTH, 14, IMEM word-address width.
- NOP_INST, 32'h0000_0013, instruction substituted on fault or invalid slot.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  downstream hazard; hold PC and output.
- redirect  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target byte address.
- bios_addra  output  BIOS_AWIDTH  BIOS port-A word address.
- bios_douta  input  32  BIOS port-A read data, valid 1 cycle after address.
- imem_addrb  output  IMEM_AWIDTH  IMEM port-B word address.
- imem_doutb  input  32  IMEM port-B read data, valid 1 cycle after address.
- pc_out  output  32  PC of inst_out.
- inst_out  output  32  fetched instruction.
- inst_valid  output  1  inst_out is a live instruction.
- fetch_fault  output  1  sticky: fetch from unmapped or misaligned address.

Behaviour:
- Address map by PC[31:28]:
  - 4'h4 → BIOS, word address PC[BIOS_AWIDTH+1:2].
  - 4'h1 or 4'h3 → IMEM, word address PC[IMEM_AWIDTH+1:2].
  - Anything else is unmapped.
- State FSM (BOOT, RUN, FAULT):
  - Reset → BOOT with pc_q=RESET_PC, inst_valid=0, fetch_fault=0.
  - BOOT lasts exactly 1 cycle, then goes to RUN.
- next_pc, evaluated in priority order:
  1. rst → RESET_PC.
  2. BOOT → pc_q.
  3. redirect → redirect_pc.
  4. stall → pc_q.
  5. otherwise pc_q+4.
  - Addition wraps modulo 2^32.
- Both memory addresses are driven combinationally from next_pc every cycle, whatever the region; the unused port's data is ignored.
- On each edge:
  - pc_q <= next_pc.
  - src_q <= region(next_pc), 2-bit: BIOS / IMEM / NONE.
- Latency:
  - An address presented in cycle N appears on inst_out in cycle N+1 with pc_out=that PC.
  - Steady-state throughput is 1 instruction/cycle.
- inst_out:
  - src_q=BIOS → bios_douta.
  - src_q=IMEM → imem_doutb.
  - NONE → NOP_INST.
- inst_valid = (state==RUN) & (src_q!=NONE) & ~redirect.
  - The redirect term combinationally kills the wrong-path slot in the cycle the redirect is seen.
- Stall:
  - next_pc=pc_q, so the same address is re-presented.
  - The memory output stays stable, and pc_out/inst_out/inst_valid hold.
  - No instruction is lost or duplicated.
- redirect with stall in the same cycle: redirect wins. The target is fetched and the current slot is killed.
- Fault:
  - Triggered when next_pc is unmapped, or a redirect has redirect_pc[1:0]!=0.
  - Next state is FAULT and fetch_fault=1.
  - While in FAULT, inst_valid=0, inst_out=NOP_INST, and pc_q holds the faulting address.
  - FAULT exits only on a redirect to an aligned, mapped address (→ RUN, fetch_fault cleared) or on rst.
- Reset mid-operation: all state returns to reset values on the next edge regardless of stall or redirect. The memories are presented RESET_PC during reset.
- No combinational path from bios_douta or imem_doutb to any address output.

Decomposition:
- Shared package rv_pkg holds:
  - RESET_PC, NOP_INST
  - region codes REGION_BIOS, REGION_IMEM, REGION_NONE
  - FSM state typedef fetch_state_t
- Sub-module pc_region_decode: combinational PC → region and misaligned flag. It is reused later by the data-side memory map.

Test Plan:
- Reset released:
  - First post-reset cycle is BOOT with inst_valid=0.
  - Next cycle: pc_out=0x4000_0000, inst_out=BIOS word 0, inst_valid=1.
  - Following cycles show pc_out=0x4000_0004, 0x4000_0008 with BIOS words 1 and 2.
- Stall held 3 cycles at pc_out=0x4000_0008:
  - pc_out, inst_out and inst_valid are unchanged for all 3 cycles.
  - After release, 0x4000_000C follows; no skip, no repeat.
- redirect=1, redirect_pc=0x1000_0000 while pc_out=0x4000_0010:
  - inst_valid=0 that cycle.
  - Next cycle: pc_out=0x1000_0000, inst_out=IMEM word 0, inst_valid=1.
- redirect and stall asserted together with redirect_pc=0x4000_0100: the next cycle shows pc_out=0x4000_0100 and BIOS word 0x40.
- Fault entry and recovery:
  - redirect_pc=0x2000_0000 → fetch_fault=1, inst_out=0x0000_0013, inst_valid=0, held with redirect deasserted.
  - redirect_pc=0x4000_0002 → fault (misaligned).
  - redirect_pc=0x4000_0000 then clears fetch_fault and resumes valid fetch.
- rst asserted mid-stream with a stall active: the next edge gives BOOT state, pc_q=0x4000_0000, inst_valid=0, fetch_fault=0.
